// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file write port.
// Each requester feeds a private FIFO; a round-robin arbiter issues at most
// one registered write per cycle and reports in-flight targets via pending_mask.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] pending_mask
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        empty;
  logic [1:0]        full;
  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_data [2];

  logic [ADDR_W-1:0] addr_mem_q [2][DEPTH];
  logic [DATA_W-1:0] data_mem_q [2][DEPTH];
  logic [PTR_W:0]    wr_ptr_q [2];
  logic [PTR_W:0]    wr_ptr_d [2];
  logic [PTR_W:0]    rd_ptr_q [2];
  logic [PTR_W:0]    rd_ptr_d [2];

  grant_e            last_grant_q, last_grant_d;
  logic              gsel;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_addr[0] = req0_addr;
  assign req_addr[1] = req1_addr;
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

  // FIFO status and accept decision; ready deliberately ignores a same-cycle pop
  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      empty[n]     = (wr_ptr_q[n] == rd_ptr_q[n]);
      full[n]      = (wr_ptr_q[n][PTR_W] != rd_ptr_q[n][PTR_W]) &&
                     (wr_ptr_q[n][PTR_W-1:0] == rd_ptr_q[n][PTR_W-1:0]);
      req_ready[n] = !full[n] && !flush;
      push[n]      = req_valid[n] && req_ready[n];
    end
  end

  // Round-robin grant over FIFO heads and next value of the write port
  always_comb begin
    pop          = '0;
    gsel         = 1'b0;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (!flush && (!empty[0] || !empty[1])) begin
      // With both heads valid the winner is the one not granted last time
      if (!empty[0] && !empty[1]) begin
        gsel = (last_grant_q == GRANT_REQ0);
      end else begin
        gsel = empty[0];
      end
      pop[gsel]    = 1'b1;
      wr_en_d      = 1'b1;
      wr_addr_d    = addr_mem_q[gsel][rd_ptr_q[gsel][PTR_W-1:0]];
      wr_data_d    = data_mem_q[gsel][rd_ptr_q[gsel][PTR_W-1:0]];
      last_grant_d = grant_e'(gsel);
    end
  end

  // Pointer advance; flush empties both FIFOs
  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      if (flush) begin
        wr_ptr_d[n] = '0;
        rd_ptr_d[n] = '0;
      end else begin
        wr_ptr_d[n] = wr_ptr_q[n] + (PTR_W+1)'(push[n]);
        rd_ptr_d[n] = rd_ptr_q[n] + (PTR_W+1)'(pop[n]);
      end
    end
  end

  // Registers targeted by any queued entry or by the write currently on the port
  always_comb begin
    logic [PTR_W:0]   occ;
    logic [PTR_W-1:0] idx;
    pending_mask = '0;
    occ          = '0;
    idx          = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      occ = wr_ptr_q[n] - rd_ptr_q[n];
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_q[n][PTR_W-1:0] + PTR_W'(k);
        if ((PTR_W+1)'(k) < occ) begin
          pending_mask[addr_mem_q[n][idx]] = 1'b1;
        end
      end
    end
    if (wr_en_q) begin
      pending_mask[wr_addr_q] = 1'b1;
    end
  end

  // Control state; asynchronous reset drops all queued and in-flight writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
      end
      last_grant_q <= GRANT_REQ1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      for (int unsigned n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
      end
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < 2; n++) begin
      if (push[n]) begin
        addr_mem_q[n][wr_ptr_q[n][PTR_W-1:0]] <= req_addr[n];
        data_mem_q[n][wr_ptr_q[n][PTR_W-1:0]] <= req_data[n];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        flush = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [3:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        r0, r1;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] pmask;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(v0), .req0_ready(r0), .req0_addr(a0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(r1), .req1_addr(a1), .req1_data(d1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending_mask(pmask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [3:0] a; logic [31:0] d; } ent_t;
  ent_t        mq0[$];
  ent_t        mq1[$];
  int          m_last;
  logic        m_en;
  logic [3:0]  m_addr;
  logic [31:0] m_data;

  function automatic void model_reset();
    mq0.delete();
    mq1.delete();
    m_last = 1;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endfunction

  function automatic logic m_rdy(int sz);
    return (!flush && sz < int'(DEPTH));
  endfunction

  function automatic logic [15:0] m_pending();
    logic [15:0] m = '0;
    foreach (mq0[i]) m[mq0[i].a] = 1'b1;
    foreach (mq1[i]) m[mq1[i].a] = 1'b1;
    if (m_en) m[m_addr] = 1'b1;
    return m;
  endfunction

  // Called just after a posedge while inputs still hold their pre-edge values
  function automatic void model_step();
    logic rd0, rd1, h0, h1;
    int   g;
    ent_t e;
    rd0 = m_rdy(mq0.size());
    rd1 = m_rdy(mq1.size());
    if (flush) begin
      mq0.delete();
      mq1.delete();
      m_en = 1'b0;
    end else begin
      h0 = (mq0.size() > 0);
      h1 = (mq1.size() > 0);
      if (h0 || h1) begin
        if (h0 && h1) g = 1 - m_last;
        else          g = h0 ? 0 : 1;
        if (g == 0) e = mq0.pop_front();
        else        e = mq1.pop_front();
        m_en   = 1'b1;
        m_addr = e.a;
        m_data = e.d;
        m_last = g;
      end else begin
        m_en = 1'b0;
      end
    end
    if (v0 && rd0) begin e = {a0, d0}; mq0.push_back(e); end
    if (v1 && rd1) begin e = {a1, d1}; mq1.push_back(e); end
  endfunction

  // ---------------- drive helpers ----------------
  task automatic set_in(input logic iv0, input logic [3:0] ia0, input logic [31:0] id0,
                        input logic iv1, input logic [3:0] ia1, input logic [31:0] id1,
                        input logic ifl);
    v0 = iv0; a0 = ia0; d0 = id0;
    v1 = iv1; a1 = ia1; d1 = id1;
    flush = ifl;
  endtask

  task automatic cyc_model(input string tag);
    #1;
    chk({tag, "_ready0"}, r0, m_rdy(mq0.size()));
    chk({tag, "_ready1"}, r1, m_rdy(mq1.size()));
    chk({tag, "_pmask"}, pmask, m_pending());
    @(posedge clk);
    model_step();
    #1;
    chk({tag, "_wr_en"}, wr_en, m_en);
    chk({tag, "_wr_addr"}, wr_addr, m_addr);
    chk({tag, "_wr_data"}, wr_data, m_data);
  endtask

  task automatic reset_dut();
    set_in(0, '0, '0, 0, '0, '0, 0);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic v0; logic [3:0] a0; logic v1; logic [3:0] a1;
    logic e_r0; logic e_r1; logic [15:0] e_pm;
    logic e_en; logic [3:0] e_addr; logic [31:0] e_data;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mkv(logic iv0, logic [3:0] ia0, logic iv1, logic [3:0] ia1,
                               logic er0, logic er1, logic [15:0] epm,
                               logic een, logic [3:0] ea, logic [31:0] ed);
    vec_t v;
    v.v0 = iv0; v.a0 = ia0; v.v1 = iv1; v.a1 = ia1;
    v.e_r0 = er0; v.e_r1 = er1; v.e_pm = epm;
    v.e_en = een; v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  initial begin
    int   s0, s1;
    int   got0[$];
    int   got1[$];
    logic acc0, acc1, ok0, ok1;

    // Contention after reset: 1,9,2,10,3,11 back to back (req1 stalls once on full)
    tbl[0] = mkv(1, 4'd1, 1, 4'd9,  1, 1, 16'h0000, 0, 4'd0,  32'h0000_0000);
    tbl[1] = mkv(1, 4'd2, 1, 4'd10, 1, 1, 16'h0202, 1, 4'd1,  32'hA000_0001);
    tbl[2] = mkv(1, 4'd3, 1, 4'd11, 1, 0, 16'h0606, 1, 4'd9,  32'hA000_0009);
    tbl[3] = mkv(0, 4'd0, 1, 4'd11, 0, 1, 16'h060C, 1, 4'd2,  32'hA000_0002);
    tbl[4] = mkv(0, 4'd0, 0, 4'd0,  1, 0, 16'h0C0C, 1, 4'd10, 32'hA000_000A);
    tbl[5] = mkv(0, 4'd0, 0, 4'd0,  1, 1, 16'h0C08, 1, 4'd3,  32'hA000_0003);
    tbl[6] = mkv(0, 4'd0, 0, 4'd0,  1, 1, 16'h0808, 1, 4'd11, 32'hA000_000B);
    tbl[7] = mkv(0, 4'd0, 0, 4'd0,  1, 1, 16'h0800, 0, 4'd11, 32'hA000_000B);

    // T1: reset values
    model_reset();
    #3;
    chk("t1_wr_en", wr_en, 1'b0);
    chk("t1_wr_addr", wr_addr, 4'd0);
    chk("t1_wr_data", wr_data, 32'd0);
    chk("t1_pmask", pmask, 16'h0000);
    chk("t1_ready0", r0, 1'b1);
    chk("t1_ready1", r1, 1'b1);
    #4;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc_model("t1_idle");
      chk("t1_idle_en_const", wr_en, 1'b0);
    end

    // T2: single write, one-cycle latency and pending visibility
    set_in(1, 4'd5, 32'hDEAD_BEEF, 0, '0, '0, 0);
    #1;
    chk("t2_pm_pre", pmask, 16'h0000);
    @(posedge clk); model_step(); #1;
    chk("t2_en_n", wr_en, 1'b0);
    set_in(0, '0, '0, 0, '0, '0, 0);
    #1;
    chk("t2_pm_n", pmask, 16'h0020);
    @(posedge clk); model_step(); #1;
    chk("t2_en_n1", wr_en, 1'b1);
    chk("t2_addr_n1", wr_addr, 4'd5);
    chk("t2_data_n1", wr_data, 32'hDEAD_BEEF);
    chk("t2_pm_n1", pmask, 16'h0020);
    @(posedge clk); model_step(); #1;
    chk("t2_en_n2", wr_en, 1'b0);
    chk("t2_pm_n2", pmask, 16'h0000);

    // T3: table-driven contention
    reset_dut();
    foreach (tbl[i]) begin
      set_in(tbl[i].v0, tbl[i].a0, 32'hA000_0000 | 32'(tbl[i].a0),
             tbl[i].v1, tbl[i].a1, 32'hA000_0000 | 32'(tbl[i].a1), 0);
      #1;
      chk($sformatf("t3_r0_row%0d", i), r0, tbl[i].e_r0);
      chk($sformatf("t3_r1_row%0d", i), r1, tbl[i].e_r1);
      chk($sformatf("t3_pm_row%0d", i), pmask, tbl[i].e_pm);
      @(posedge clk); model_step(); #1;
      chk($sformatf("t3_en_row%0d", i), wr_en, tbl[i].e_en);
      chk($sformatf("t3_addr_row%0d", i), wr_addr, tbl[i].e_addr);
      chk($sformatf("t3_data_row%0d", i), wr_data, tbl[i].e_data);
    end

    // T4: full FIFOs under sustained handshakes, no loss or duplication
    reset_dut();
    s0 = 0;
    s1 = 0;
    for (int c = 0; c < 60; c++) begin
      if (s0 >= 6 && s1 >= 6 && mq0.size() == 0 && mq1.size() == 0 && !m_en) break;
      set_in(s0 < 6, 4'(s0), 32'h0000_0000 | 32'(s0),
             s1 < 6, 4'(8 + s1), 32'h0001_0000 | 32'(s1), 0);
      acc0 = v0 && m_rdy(mq0.size());
      acc1 = v1 && m_rdy(mq1.size());
      cyc_model("t4");
      if (wr_en) begin
        if (wr_data[16]) got1.push_back(int'(wr_data[15:0]));
        else             got0.push_back(int'(wr_data[15:0]));
      end
      if (acc0) s0++;
      if (acc1) s1++;
    end
    ok0 = (got0.size() == 6);
    ok1 = (got1.size() == 6);
    foreach (got0[i]) if (got0[i] != i) ok0 = 1'b0;
    foreach (got1[i]) if (got1[i] != i) ok1 = 1'b0;
    chk("t4_accepted", (s0 == 6) && (s1 == 6), 1'b1);
    chk("t4_order0", ok0, 1'b1);
    chk("t4_order1", ok1, 1'b1);

    // T5: flush discards queued writes and blocks same-cycle enqueue
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 4'(4 + i), 32'h5000_0000 | 32'(i), 1, 4'(12 + i), 32'h5100_0000 | 32'(i), 0);
      cyc_model("t5_fill");
    end
    set_in(1, 4'd7, 32'h5555_5555, 1, 4'd15, 32'h6666_6666, 1);
    #1;
    chk("t5_ready0_flush", r0, 1'b0);
    chk("t5_ready1_flush", r1, 1'b0);
    @(posedge clk); model_step(); #1;
    chk("t5_en_after", wr_en, 1'b0);
    set_in(0, '0, '0, 0, '0, '0, 0);
    #1;
    chk("t5_pm_after", pmask, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      cyc_model("t5_idle");
      chk("t5_idle_en_const", wr_en, 1'b0);
    end

    // T6: asynchronous reset in the middle of a burst
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 4'(1 + i), 32'h6000_0000 | 32'(i), 1, 4'(9 + i), 32'h6100_0000 | 32'(i), 0);
      cyc_model("t6_burst");
    end
    chk("t6_busy_before", wr_en, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_en_async", wr_en, 1'b0);
    chk("t6_pm_async", pmask, 16'h0000);
    chk("t6_ready0_async", r0, 1'b1);
    chk("t6_ready1_async", r1, 1'b1);
    model_reset();
    set_in(0, '0, '0, 0, '0, '0, 0);
    #1;
    rst = 1'b1;
    set_in(1, 4'd7, 32'h7777_0000, 1, 4'd8, 32'h8888_0000, 0);
    cyc_model("t6_offer");
    set_in(0, '0, '0, 0, '0, '0, 0);
    cyc_model("t6_first");
    chk("t6_first_addr", wr_addr, 4'd7);
    chk("t6_first_data", wr_data, 32'h7777_0000);
    cyc_model("t6_second");

    // Randomized traffic against the model
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
             1'($urandom_range(0, 1)), 4'($urandom), $urandom,
             $urandom_range(0, 19) == 0);
      cyc_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
